// File: rtl/bsg_gateway_clk_pkg.sv
// Shared definitions for the gateway clock-divider bank.
//   bank_state_e  : lock sequencing states of the bank
//   chan_cfg_s    : per-channel configuration (enable + half-period divide value)
//   ch_width()    : width of a channel-select field for a given channel count
package bsg_gateway_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RUN       = 2'd2
  } bank_state_e;

  // Divide values are carried at this fixed width inside the struct so the
  // struct stays parameter-free; div_width_p of the bank must not exceed it.
  localparam int unsigned max_div_width_lp = 16;

  typedef struct packed {
    logic                        en;
    logic [max_div_width_lp-1:0] div;
  } chan_cfg_s;

  function automatic int unsigned ch_width(input int unsigned n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  // Channel-select width for the default four-channel bank.
  localparam int unsigned default_cfg_ch_width_lp = ch_width(4);

endpackage

// File: rtl/bsg_gateway_clk_div_chan.sv
// One divided-clock channel of the gateway clock bank.
// Ports:
//   clk_i, reset_i : bank clock and synchronous active-high reset
//   run_i          : bank is in RUN with lock present; low forces the channel idle
//   wr_v_i         : accepted configuration transfer for this channel
//   wr_cfg_i       : configuration carried by the transfer
//   pending_o      : a shadow configuration waits for the next low-phase terminal
//   clk_o          : divided clock (phase flop)
//   tick_o         : one-cycle pulse in the cycle clk_o becomes 1
module bsg_gateway_clk_div_chan
  import bsg_gateway_clk_pkg::*;
#(
  parameter int unsigned div_width_p   = 8,
  parameter int unsigned default_div_p = 2
) (
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      run_i,
  input  logic      wr_v_i,
  input  chan_cfg_s wr_cfg_i,
  output logic      pending_o,
  output logic      clk_o,
  output logic      tick_o
);

  chan_cfg_s              cfg_r, cfg_n;
  chan_cfg_s              shadow_r, shadow_n;
  logic                   pending_r, pending_n;
  logic [div_width_p-1:0] cnt_r, cnt_n;
  logic                   phase_r, phase_n;
  logic                   tick_r, tick_n;
  logic                   term_s;
  logic                   immediate_s;

  // Terminal count of the current half period.
  assign term_s = (max_div_width_lp'(cnt_r) == cfg_r.div);

  // A config can land at once when nothing is being generated; otherwise it
  // waits in the shadow so no half period is ever cut short or stretched.
  assign immediate_s = ~run_i | (~cfg_r.en & ~phase_r);

  // Divider, commit and accept next-state logic.
  always_comb begin
    cfg_n     = cfg_r;
    shadow_n  = shadow_r;
    pending_n = pending_r;
    cnt_n     = cnt_r;
    phase_n   = phase_r;
    tick_n    = 1'b0;

    if (~run_i) begin
      // Lock lost or not yet running: clear the divider, keep config/pending.
      cnt_n   = '0;
      phase_n = 1'b0;
    end else if (~cfg_r.en) begin
      cnt_n   = '0;
      phase_n = 1'b0;
    end else if (term_s) begin
      cnt_n = '0;
      if (~phase_r & pending_r) begin
        // Low-phase terminal: the shadow takes over. A committed disable
        // suppresses the rise so the clock parks low.
        cfg_n     = shadow_r;
        pending_n = 1'b0;
        phase_n   = shadow_r.en;
        tick_n    = shadow_r.en;
      end else begin
        phase_n = ~phase_r;
        tick_n  = ~phase_r;
      end
    end else begin
      cnt_n = cnt_r + div_width_p'(1);
    end

    // wr_v_i is never high while pending, so this cannot collide with a commit.
    case ({wr_v_i, immediate_s})
      2'b11: cfg_n = wr_cfg_i;
      2'b10: begin
        shadow_n  = wr_cfg_i;
        pending_n = 1'b1;
      end
      default: begin
        cfg_n = cfg_n;
      end
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cfg_r     <= '{en: 1'b0, div: max_div_width_lp'(default_div_p)};
      shadow_r  <= '{en: 1'b0, div: max_div_width_lp'(default_div_p)};
      pending_r <= 1'b0;
      cnt_r     <= '0;
      phase_r   <= 1'b0;
      tick_r    <= 1'b0;
    end else begin
      cfg_r     <= cfg_n;
      shadow_r  <= shadow_n;
      pending_r <= pending_n;
      cnt_r     <= cnt_n;
      phase_r   <= phase_n;
      tick_r    <= tick_n;
    end
  end

  assign pending_o = pending_r;
  assign clk_o     = phase_r;
  assign tick_o    = tick_r;

endmodule

// File: rtl/bsg_gateway_clk_div_bank.sv
// Runtime-programmable bank of fabric-divided clocks fed by one PLL clock.
// Ports:
//   clk_i        : bank clock (PLL output through a global buffer)
//   reset_i      : synchronous active-high reset
//   pll_locked_i : PLL lock, asynchronous to clk_i
//   cfg_v_i, cfg_ch_i, cfg_div_i, cfg_en_i, cfg_ready_o : config handshake
//   clk_o        : divided clocks, period 2*(div+1)
//   tick_o       : one-cycle pulse in the cycle each clk_o bit rises
//   locked_o     : bank running with lock present
//   reset_o      : downstream synchronous reset, released reset_hold_p cycles into RUN
module bsg_gateway_clk_div_bank
  import bsg_gateway_clk_pkg::*;
#(
  parameter int unsigned channels_p    = 4,
  parameter int unsigned div_width_p   = 8,
  parameter int unsigned default_div_p = 2,
  parameter int unsigned lock_filter_p = 16,
  parameter int unsigned reset_hold_p  = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            pll_locked_i,
  input  logic                            cfg_v_i,
  input  logic [ch_width(channels_p)-1:0] cfg_ch_i,
  input  logic [div_width_p-1:0]          cfg_div_i,
  input  logic                            cfg_en_i,
  output logic                            cfg_ready_o,
  output logic [channels_p-1:0]           clk_o,
  output logic [channels_p-1:0]           tick_o,
  output logic                            locked_o,
  output logic                            reset_o
);

  localparam int unsigned ch_width_lp   = ch_width(channels_p);
  localparam int unsigned filt_width_lp = $clog2(lock_filter_p + 1);
  localparam int unsigned hold_width_lp = $clog2(reset_hold_p + 1);

  logic                     lk_meta_r;
  logic                     lk_s;
  bank_state_e              state_r, state_n;
  logic [filt_width_lp-1:0] filt_r, filt_n;
  logic [hold_width_lp-1:0] hold_r;
  logic                     reset_r;
  logic                     run_s;
  logic                     ready_s;
  logic [channels_p-1:0]    pending_s;
  logic [channels_p-1:0]    wr_v_s;
  logic [channels_p-1:0]    clk_raw_s;
  logic [channels_p-1:0]    tick_raw_s;
  chan_cfg_s                wr_cfg_s;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lk_meta_r <= 1'b0;
      lk_s      <= 1'b0;
    end else begin
      lk_meta_r <= pll_locked_i;
      lk_s      <= lk_meta_r;
    end
  end

  // Lock sequencing; the first lk_s=1 cycle in WAIT_LOCK counts toward the filter.
  always_comb begin
    state_n = state_r;
    filt_n  = filt_r;
    case (state_r)
      WAIT_LOCK: begin
        if (lk_s) begin
          if (lock_filter_p == 1) begin
            state_n = RUN;
            filt_n  = '0;
          end else begin
            state_n = FILTER;
            filt_n  = filt_width_lp'(1);
          end
        end else begin
          filt_n = '0;
        end
      end
      FILTER: begin
        if (~lk_s) begin
          state_n = WAIT_LOCK;
          filt_n  = '0;
        end else if (filt_r == filt_width_lp'(lock_filter_p - 1)) begin
          state_n = RUN;
          filt_n  = '0;
        end else begin
          filt_n = filt_r + filt_width_lp'(1);
        end
      end
      RUN: begin
        if (~lk_s) begin
          state_n = WAIT_LOCK;
        end else begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = WAIT_LOCK;
        filt_n  = '0;
      end
    endcase
  end

  // FSM state and lock-filter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= WAIT_LOCK;
      filt_r  <= '0;
    end else begin
      state_r <= state_n;
      filt_r  <= filt_n;
    end
  end

  // Qualifying RUN with lk_s makes a lock drop act in the very cycle it is seen.
  assign run_s = (state_r == RUN) & lk_s;

  // Downstream reset hold counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_r  <= '0;
      reset_r <= 1'b1;
    end else if (~run_s) begin
      hold_r  <= '0;
      reset_r <= 1'b1;
    end else if (hold_r == hold_width_lp'(reset_hold_p - 1)) begin
      hold_r  <= hold_r;
      reset_r <= 1'b0;
    end else begin
      hold_r  <= hold_r + hold_width_lp'(1);
      reset_r <= reset_r;
    end
  end

  // Ready reflects only the addressed channel; out-of-range selects are always ready.
  always_comb begin
    ready_s = 1'b1;
    for (int c = 0; c < channels_p; c++) begin
      ready_s = ready_s & ~(pending_s[c] & (cfg_ch_i == ch_width_lp'(c)));
    end
  end

  assign wr_cfg_s = '{en: cfg_en_i, div: max_div_width_lp'(cfg_div_i)};

  for (genvar c = 0; c < channels_p; c++) begin : g_chan
    assign wr_v_s[c] = cfg_v_i & (cfg_ch_i == ch_width_lp'(c)) & ~pending_s[c];

    bsg_gateway_clk_div_chan #(
      .div_width_p  (div_width_p),
      .default_div_p(default_div_p)
    ) u_chan (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .run_i    (run_s),
      .wr_v_i   (wr_v_s[c]),
      .wr_cfg_i (wr_cfg_s),
      .pending_o(pending_s[c]),
      .clk_o    (clk_raw_s[c]),
      .tick_o   (tick_raw_s[c])
    );
  end

  assign cfg_ready_o = ready_s;
  assign clk_o       = clk_raw_s & {channels_p{run_s}};
  assign tick_o      = tick_raw_s & {channels_p{run_s}};
  assign locked_o    = run_s;
  assign reset_o     = reset_r | ~run_s;

endmodule

// File: tb/tb_bsg_gateway_clk_div_bank.sv
// Directed bench for bsg_gateway_clk_div_bank (3 channels so that
// cfg_ch_i = 3 is a representable out-of-range select).
module tb_bsg_gateway_clk_div_bank;

  logic       clk;
  logic       reset_i;
  logic       pll_locked_i;
  logic       cfg_v_i;
  logic [1:0] cfg_ch_i;
  logic [7:0] cfg_div_i;
  logic       cfg_en_i;
  logic       cfg_ready_o;
  logic [2:0] clk_o;
  logic [2:0] tick_o;
  logic       locked_o;
  logic       reset_o;

  int checks = 0;
  int passes = 0;

  bsg_gateway_clk_div_bank #(
    .channels_p   (3),
    .div_width_p  (8),
    .default_div_p(2),
    .lock_filter_p(16),
    .reset_hold_p (8)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .pll_locked_i(pll_locked_i),
    .cfg_v_i     (cfg_v_i),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_div_i   (cfg_div_i),
    .cfg_en_i    (cfg_en_i),
    .cfg_ready_o (cfg_ready_o),
    .clk_o       (clk_o),
    .tick_o      (tick_o),
    .locked_o    (locked_o),
    .reset_o     (reset_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic       e0;
    logic       e1;
    logic       t1;
    reset_i      = 1'b1;
    pll_locked_i = 1'b0;
    cfg_v_i      = 1'b0;
    cfg_ch_i     = 2'd0;
    cfg_div_i    = 8'd0;
    cfg_en_i     = 1'b0;

    // Test 1: reset values, then lock -> RUN after 2+16, reset_o drops 8 later.
    repeat (3) step();
    chk("rst_clk", 32'(clk_o), 32'd0);
    chk("rst_tick", 32'(tick_o), 32'd0);
    chk("rst_locked", 32'(locked_o), 32'd0);
    chk("rst_reset_o", 32'(reset_o), 32'd1);
    chk("rst_ready", 32'(cfg_ready_o), 32'd1);
    reset_i      = 1'b0;
    pll_locked_i = 1'b1;
    repeat (17) step();
    chk("t1_locked_p17", 32'(locked_o), 32'd0);
    step();
    chk("t1_locked_p18", 32'(locked_o), 32'd1);
    chk("t1_reset_p18", 32'(reset_o), 32'd1);
    repeat (7) step();
    chk("t1_reset_p25", 32'(reset_o), 32'd1);
    step();
    chk("t1_reset_p26", 32'(reset_o), 32'd0);

    // Reset mid-RUN wins over everything.
    reset_i      = 1'b1;
    pll_locked_i = 1'b0;
    repeat (2) step();
    chk("rst2_locked", 32'(locked_o), 32'd0);
    chk("rst2_reset_o", 32'(reset_o), 32'd1);

    // Test 2: 10 cycles locked, 1 low, relock -> filter restarts.
    reset_i      = 1'b0;
    pll_locked_i = 1'b1;
    repeat (10) step();
    pll_locked_i = 1'b0;
    step();
    pll_locked_i = 1'b1;
    repeat (7) step();
    chk("t2_locked_q18", 32'(locked_o), 32'd0);
    repeat (10) step();
    chk("t2_locked_q28", 32'(locked_o), 32'd0);
    step();
    chk("t2_locked_q29", 32'(locked_o), 32'd1);
    repeat (7) step();
    chk("t2_reset_q36", 32'(reset_o), 32'd1);
    step();
    chk("t2_reset_q37", 32'(reset_o), 32'd0);

    // Test 3: ch0 div=2 en=1 -> 3 high / 3 low, first rise 3 cycles after enable.
    cfg_v_i   = 1'b1;
    cfg_ch_i  = 2'd0;
    cfg_div_i = 8'd2;
    cfg_en_i  = 1'b1;
    #1;
    chk("t3_ready", 32'(cfg_ready_o), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) cfg_v_i = 1'b0;
      e0 = (((k - 1) / 3) % 2) == 1;
      chk($sformatf("t3_clk_%0d", k), 32'(clk_o), 32'({2'b00, e0}));
      chk($sformatf("t3_tick_%0d", k), 32'(tick_o), 32'({2'b00, e0 && ((k - 1) % 3 == 0)}));
    end

    // Test 3/4: div=0 pends until the low terminal; a second ch0 cfg is refused,
    // a ch1 cfg is accepted meanwhile.
    cfg_v_i   = 1'b1;
    cfg_div_i = 8'd0;
    step();
    cfg_div_i = 8'd5;
    #1;
    chk("t4_ready_ch0_pend", 32'(cfg_ready_o), 32'd0);
    chk("t3_clk_13", 32'(clk_o), 32'd0);
    step();
    chk("t3_clk_14", 32'(clk_o), 32'd0);
    cfg_ch_i  = 2'd1;
    cfg_div_i = 8'd1;
    #1;
    chk("t4_ready_ch1", 32'(cfg_ready_o), 32'd1);
    step();
    cfg_v_i  = 1'b0;
    cfg_ch_i = 2'd0;
    #1;
    chk("t4_ready_ch0_r15", 32'(cfg_ready_o), 32'd0);
    for (int k = 15; k <= 24; k++) begin
      if (k > 15) step();
      e0 = (k >= 16) && ((k - 16) % 2 == 0);
      e1 = (((k - 15) / 2) % 2) == 1;
      t1 = e1 && ((k - 15) % 2 == 0);
      chk($sformatf("t4_clk_%0d", k), 32'(clk_o), 32'({1'b0, e1, e0}));
      chk($sformatf("t4_tick_%0d", k), 32'(tick_o), 32'({1'b0, t1, e0}));
      if (k == 16) chk("t4_ready_ch0_commit", 32'(cfg_ready_o), 32'd1);
    end

    // Test 5: lock drops during a high phase; outputs forced 2 cycles later.
    pll_locked_i = 1'b0;
    step();
    chk("t5_clk_r25", 32'(clk_o), 32'b010);
    chk("t5_locked_r25", 32'(locked_o), 32'd1);
    step();
    chk("t5_clk_r26", 32'(clk_o), 32'd0);
    chk("t5_tick_r26", 32'(tick_o), 32'd0);
    chk("t5_locked_r26", 32'(locked_o), 32'd0);
    chk("t5_reset_r26", 32'(reset_o), 32'd1);
    step();
    pll_locked_i = 1'b1;
    repeat (17) step();
    chk("t5_locked_s17", 32'(locked_o), 32'd0);
    step();
    chk("t5_locked_s18", 32'(locked_o), 32'd1);
    chk("t5_clk_s18", 32'(clk_o), 32'd0);
    step();
    chk("t5_clk_s19", 32'(clk_o), 32'b001);
    chk("t5_tick_s19", 32'(tick_o), 32'b001);
    step();
    chk("t5_clk_s20", 32'(clk_o), 32'b010);
    chk("t5_tick_s20", 32'(tick_o), 32'b010);

    // Test 6: out-of-range select is accepted and ignored.
    cfg_v_i   = 1'b1;
    cfg_ch_i  = 2'd3;
    cfg_div_i = 8'd0;
    cfg_en_i  = 1'b1;
    #1;
    chk("t6_ready_oor", 32'(cfg_ready_o), 32'd1);
    step();
    cfg_v_i = 1'b0;
    chk("t6_clk_s21", 32'(clk_o), 32'b011);
    step();
    chk("t6_clk_s22", 32'(clk_o), 32'b000);
    step();
    chk("t6_clk_s23", 32'(clk_o), 32'b001);

    // Test 6: disable ch1 -> finishes the current period and parks low.
    cfg_v_i   = 1'b1;
    cfg_ch_i  = 2'd1;
    cfg_div_i = 8'd1;
    cfg_en_i  = 1'b0;
    #1;
    chk("t6_ready_dis", 32'(cfg_ready_o), 32'd1);
    for (int k = 24; k <= 31; k++) begin
      step();
      if (k == 24) begin
        cfg_v_i = 1'b0;
        chk("t6_ready_dis_pend", 32'(cfg_ready_o), 32'd0);
      end
      e0 = (k % 2) == 1;
      e1 = (k == 24) || (k == 25);
      chk($sformatf("t6_clk_%0d", k), 32'(clk_o), 32'({1'b0, e1, e0}));
      chk($sformatf("t6_tick_%0d", k), 32'(tick_o), 32'({1'b0, k == 24, e0}));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
